pe_feeder: RTL and testbench

Issue stage directly upstream of the systolic PE. Accepts a beat stream of complex 12-bit samples, pairs consecutive beats into (x, y) operands, and buffers the pairs in a small FIFO. Launches one PE operation per pair with a single-cycle trigger and the correct CORDIC mode. Holds the next launch until the PE reports completion.

---
 rtl/qr_pkg.sv | 23 ++
 rtl/pe_feeder_fifo.sv | 56 +++++
 rtl/pe_feeder.sv | 166 ++++++++++++++++
 tb/tb_pe_feeder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qr_pkg.sv
// Shared types and constants for the QR systolic datapath: mode encodings,
// feeder FSM states and the (x, y, mode) operand pair carried to a PE.
package qr_pkg;

    localparam int DATA_W = 12;

    localparam logic M_VECTORING = 1'b1;
    localparam logic M_ROTATION  = 1'b0;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } feeder_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] real_x;
        logic [DATA_W-1:0] imag_x;
        logic [DATA_W-1:0] real_y;
        logic [DATA_W-1:0] imag_y;
        logic              mode;
    } pair_t;

endpackage

// File: rtl/pe_feeder_fifo.sv
// Synchronous pair FIFO with show-ahead read data, full/empty flags and
// occupancy count. A write while full is taken only if a pop happens alongside.
module pe_feeder_fifo #(
    parameter int WIDTH = 49,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_wr;
    logic             do_rd;

    assign o_full    = (count_q == (AW + 1)'(DEPTH));
    assign o_empty   = (count_q == '0);
    assign o_count   = count_q;
    assign o_rd_data = mem_q[rd_ptr_q];
    assign do_rd     = i_rd_en && !o_empty;
    assign do_wr     = i_wr_en && (!o_full || do_rd);

    always_ff @(posedge i_clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pe_feeder.sv
// Pairs input beats into (x, y) operands, queues them and launches one PE
// operation at a time. Optional watchdog enabled by PE_FEEDER_TIMEOUT_EN.
module pe_feeder #(
    parameter int DATA_W     = qr_pkg::DATA_W,
    parameter int N_COL      = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_real,
    input  logic [DATA_W-1:0] i_imag,
    output logic              o_ready,
    output logic              o_trig,
    output logic [DATA_W-1:0] o_real_x,
    output logic [DATA_W-1:0] o_imag_x,
    output logic [DATA_W-1:0] o_real_y,
    output logic [DATA_W-1:0] o_imag_y,
    output logic              o_mode_x,
    output logic              o_mode_y,
    input  logic              i_finish,
    output logic              o_row_done,
    output logic              o_busy,
    output logic              o_err
);
    import qr_pkg::*;

    localparam int COL_W  = (N_COL > 1) ? $clog2(N_COL) : 1;
    localparam int PAIR_W = 4 * DATA_W + 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(N_COL - 1);

    feeder_state_e state_q, state_d;
    logic              half_q;
    logic [DATA_W-1:0] x_real_q, x_imag_q;
    logic [COL_W-1:0]  wr_col_q, launch_col_q;
    logic              trig_q, row_done_q, row_done_d, inflight_last_q;
    logic [DATA_W-1:0] real_x_q, imag_x_q, real_y_q, imag_y_q;
    logic              mode_q;
    logic              accept, launch, finish_ok, timeout_hit;
    logic              fifo_full, fifo_empty;
    logic [PAIR_W-1:0] fifo_wdata, fifo_rdata;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign accept     = i_valid && !fifo_full;
    assign finish_ok  = i_finish && !trig_q;
    assign fifo_wdata = {x_real_q, x_imag_q, i_real, i_imag,
                         (wr_col_q == '0) ? M_VECTORING : M_ROTATION};

    pe_feeder_fifo #(
        .WIDTH (PAIR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (accept && half_q),
        .i_wr_data (fifo_wdata),
        .i_rd_en   (launch),
        .o_rd_data (fifo_rdata),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty),
        .o_count   (fifo_count)
    );

    // First beat of a pair is held as x; the second completes the FIFO entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            half_q   <= 1'b0;
            x_real_q <= '0;
            x_imag_q <= '0;
            wr_col_q <= '0;
        end else if (accept) begin
            half_q <= !half_q;
            if (!half_q) begin
                x_real_q <= i_real;
                x_imag_q <= i_imag;
            end else begin
                wr_col_q <= (wr_col_q == LAST_COL) ? '0 : wr_col_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        launch     = 1'b0;
        row_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    launch  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (finish_ok) begin
                    row_done_d = inflight_last_q;
                    if (!fifo_empty) launch  = 1'b1;
                    else             state_d = IDLE;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Launch order equals write order, so a separate column count tracks row ends.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q         <= IDLE;
            trig_q          <= 1'b0;
            row_done_q      <= 1'b0;
            real_x_q        <= '0;
            imag_x_q        <= '0;
            real_y_q        <= '0;
            imag_y_q        <= '0;
            mode_q          <= 1'b0;
            inflight_last_q <= 1'b0;
            launch_col_q    <= '0;
        end else begin
            state_q    <= state_d;
            trig_q     <= launch;
            row_done_q <= row_done_d;
            if (launch) begin
                {real_x_q, imag_x_q, real_y_q, imag_y_q, mode_q} <= fifo_rdata;
                inflight_last_q <= (launch_col_q == LAST_COL);
                launch_col_q    <= (launch_col_q == LAST_COL) ? '0 : launch_col_q + 1'b1;
            end
        end
    end

`ifdef PE_FEEDER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wdog_q;
    logic            err_q;

    assign timeout_hit = (state_q == WAIT) && (wdog_q == WD_W'(TIMEOUT - 1));
    assign o_err       = err_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= timeout_hit && !finish_ok;
            if (launch)                wdog_q <= '0;
            else if (state_q == WAIT)  wdog_q <= wdog_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign o_err       = 1'b0;
`endif

    assign o_ready    = !fifo_full;
    assign o_trig     = trig_q;
    assign o_real_x   = real_x_q;
    assign o_imag_x   = imag_x_q;
    assign o_real_y   = real_y_q;
    assign o_imag_y   = imag_y_q;
    assign o_mode_x   = mode_q;
    assign o_mode_y   = mode_q;
    assign o_row_done = row_done_q;
    assign o_busy     = (state_q != IDLE) || (fifo_count != '0) || half_q;

endmodule

// File: tb/tb_pe_feeder.sv
// Directed self-checking bench for pe_feeder (default parameters); the
// watchdog scenario is exercised when PE_FEEDER_TIMEOUT_EN is defined.
module tb_pe_feeder;
    localparam int DW = 12;

    logic          clk;
    logic          rst;
    logic          i_valid;
    logic [DW-1:0] i_real, i_imag;
    logic          o_ready, o_trig;
    logic [DW-1:0] o_real_x, o_imag_x, o_real_y, o_imag_y;
    logic          o_mode_x, o_mode_y;
    logic          i_finish;
    logic          o_row_done, o_busy, o_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int consec_trig = 0;
    logic prev_trig = 1'b0;

    pe_feeder dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (i_valid),
        .i_real     (i_real),
        .i_imag     (i_imag),
        .o_ready    (o_ready),
        .o_trig     (o_trig),
        .o_real_x   (o_real_x),
        .o_imag_x   (o_imag_x),
        .o_real_y   (o_real_y),
        .o_imag_y   (o_imag_y),
        .o_mode_x   (o_mode_x),
        .o_mode_y   (o_mode_y),
        .i_finish   (i_finish),
        .o_row_done (o_row_done),
        .o_busy     (o_busy),
        .o_err      (o_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_trig && prev_trig) consec_trig++;
        prev_trig = o_trig;
    end

    // Beat b of the backpressure stream carries real = b*16, imag = b*3.
    function automatic logic [DW-1:0] br(input int b);
        return DW'(b * 16);
    endfunction
    function automatic logic [DW-1:0] bi(input int b);
        return DW'(b * 3);
    endfunction

    task automatic do_reset();
        rst = 1'b1; i_valid = 1'b0; i_finish = 1'b0; i_real = '0; i_imag = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] re, input logic [DW-1:0] im);
        int   n;
        logic rdy;
        n = 0;
        i_valid = 1'b1; i_real = re; i_imag = im;
        rdy = o_ready;
        @(negedge clk);
        while (!rdy && n < 200) begin
            rdy = o_ready;
            @(negedge clk);
            n++;
        end
        i_valid = 1'b0;
        checks++;
        if (!rdy) begin errors++; $display("FAIL beat_accept: ready=%b want 1 within 200 cycles", rdy); end
    endtask

    task automatic wait_trig(output int t);
        int n;
        n = 0;
        while (o_trig !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        checks++;
        if (o_trig !== 1'b1) begin errors++; $display("FAIL trig_timeout: o_trig=%b want 1 within 20 cycles", o_trig); end
    endtask

    task automatic pulse_finish();
        i_finish = 1'b1;
        @(negedge clk);
        i_finish = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_trig !== 1'b0) begin errors++; $display("FAIL reset_trig: got %b want 0", o_trig); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_ready); end
        checks++; if ({o_real_x, o_imag_x, o_real_y, o_imag_y, o_mode_x, o_mode_y, o_row_done, o_err} !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h/%h/%h/%h m%b%b rd%b err%b want all 0",
                               o_real_x, o_imag_x, o_real_y, o_imag_y, o_mode_x, o_mode_y, o_row_done, o_err);
        end
    endtask

    task automatic test_basic();
        do_reset();
        send_beat(12'h100, 12'h000);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL basic_half_busy: got %b want 1", o_busy); end
        send_beat(12'h080, 12'h040);
        checks++; if (o_trig !== 1'b0) begin errors++; $display("FAIL basic_trig_t1: got %b want 0", o_trig); end
        @(negedge clk);
        checks++; if (o_trig !== 1'b1) begin errors++; $display("FAIL basic_trig_t2: got %b want 1", o_trig); end
        checks++; if ({o_real_x, o_imag_x, o_real_y, o_imag_y} !== {12'h100, 12'h000, 12'h080, 12'h040}) begin
            errors++; $display("FAIL basic_operands: got %h %h %h %h want 100 000 080 040", o_real_x, o_imag_x, o_real_y, o_imag_y);
        end
        checks++; if ({o_mode_x, o_mode_y} !== 2'b11) begin errors++; $display("FAIL basic_mode: got %b%b want 11", o_mode_x, o_mode_y); end
        @(negedge clk);
        checks++; if (o_trig !== 1'b0 || o_real_x !== 12'h100) begin
            errors++; $display("FAIL basic_hold: trig=%b real_x=%h want 0 100", o_trig, o_real_x);
        end
        pulse_finish();
        checks++; if (o_busy !== 1'b0 || o_row_done !== 1'b0 || o_trig !== 1'b0) begin
            errors++; $display("FAIL basic_done: busy=%b row_done=%b trig=%b want 000", o_busy, o_row_done, o_trig);
        end
    endtask

    task automatic test_row();
        int t;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_beat(DW'(12'h200 + i * 16), 12'h0F0);
            send_beat(12'h0A0, DW'(12'h300 + i));
            if (i == 0) wait_trig(t);
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (o_mode_x !== (i == 0) || o_mode_y !== (i == 0)) begin
                errors++; $display("FAIL row_mode%0d: got %b%b want %0d", i, o_mode_x, o_mode_y, (i == 0));
            end
            checks++; if (o_real_x !== DW'(12'h200 + i * 16) || o_imag_y !== DW'(12'h300 + i)) begin
                errors++; $display("FAIL row_data%0d: got %h %h want %h %h", i, o_real_x, o_imag_y,
                                   DW'(12'h200 + i * 16), DW'(12'h300 + i));
            end
            while (cyc < t + 14) @(negedge clk);
            pulse_finish();
            checks++; if (o_trig !== (i < 3)) begin errors++; $display("FAIL row_relaunch%0d: got %b want %0d", i, o_trig, (i < 3)); end
            checks++; if (o_row_done !== (i == 3)) begin errors++; $display("FAIL row_done%0d: got %b want %0d", i, o_row_done, (i == 3)); end
            t = cyc;
        end
        @(negedge clk);
        checks++; if (o_row_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL row_end: row_done=%b busy=%b want 00", o_row_done, o_busy);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        // Pair 1 launches early, so the FIFO fills on the 18th beat (pairs 2..9).
        for (int b = 1; b <= 18; b++) begin
            send_beat(br(b), bi(b));
            if (b == 17) begin
                checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_ready17: got %b want 1", o_ready); end
            end
        end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready18: got %b want 0", o_ready); end
        i_valid = 1'b1; i_real = br(19); i_imag = bi(19);
        repeat (3) begin
            @(negedge clk);
            checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_stall: ready=%b want 0", o_ready); end
        end
        pulse_finish();
        checks++; if (o_trig !== 1'b1 || o_ready !== 1'b1) begin
            errors++; $display("FAIL bp_pop: trig=%b ready=%b want 11", o_trig, o_ready);
        end
        checks++; if (o_real_x !== br(3) || o_imag_y !== bi(4)) begin
            errors++; $display("FAIL bp_pair2: got %h %h want %h %h", o_real_x, o_imag_y, br(3), bi(4));
        end
        send_beat(br(19), bi(19));
        send_beat(br(20), bi(20));
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_refill: ready=%b want 0", o_ready); end
        for (int k = 3; k <= 10; k++) begin
            @(negedge clk);
            pulse_finish();
            checks++; if (o_trig !== 1'b1) begin errors++; $display("FAIL b2b_trig%0d: got %b want 1", k, o_trig); end
            checks++; if (o_real_x !== br(2 * k - 1) || o_imag_y !== bi(2 * k)) begin
                errors++; $display("FAIL b2b_data%0d: got %h %h want %h %h", k, o_real_x, o_imag_y, br(2 * k - 1), bi(2 * k));
            end
            checks++; if (o_mode_x !== ((k - 1) % 4 == 0)) begin errors++; $display("FAIL b2b_mode%0d: got %b want %0d", k, o_mode_x, ((k - 1) % 4 == 0)); end
            checks++; if (o_row_done !== ((k - 2) % 4 == 3)) begin errors++; $display("FAIL b2b_row%0d: got %b want %0d", k, o_row_done, ((k - 2) % 4 == 3)); end
        end
        @(negedge clk);
        pulse_finish();
        checks++; if (o_trig !== 1'b0 || o_row_done !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL bp_drain: trig=%b row_done=%b busy=%b want 000", o_trig, o_row_done, o_busy);
        end
    endtask

    task automatic test_ignored_finish();
        int t;
        do_reset();
        pulse_finish();
        checks++; if (o_busy !== 1'b0 || o_trig !== 1'b0) begin errors++; $display("FAIL ign_idle: busy=%b trig=%b want 00", o_busy, o_trig); end
        send_beat(12'h111, 12'h222);
        send_beat(12'h333, 12'h444);
        wait_trig(t);
        pulse_finish();
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL ign_trigcycle_busy: got %b want 1", o_busy); end
        send_beat(12'h555, 12'h666);
        send_beat(12'h777, 12'h888);
        repeat (3) @(negedge clk);
        checks++; if (o_trig !== 1'b0 || o_real_x !== 12'h111) begin
            errors++; $display("FAIL ign_nopop: trig=%b real_x=%h want 0 111", o_trig, o_real_x);
        end
        pulse_finish();
        checks++; if (o_trig !== 1'b1 || o_real_x !== 12'h555 || o_imag_y !== 12'h888) begin
            errors++; $display("FAIL ign_relaunch: trig=%b %h %h want 1 555 888", o_trig, o_real_x, o_imag_y);
        end
        @(negedge clk);
        pulse_finish();
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ign_end_busy: got %b want 0", o_busy); end
    endtask

    task automatic test_reset_mid();
        int t;
        do_reset();
        send_beat(12'h0AA, 12'h0BB);
        send_beat(12'h0CC, 12'h0DD);
        wait_trig(t);
        for (int i = 0; i < 3; i++) begin
            send_beat(DW'(12'h400 + i), 12'h001);
            send_beat(12'h002, 12'h003);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({o_trig, o_real_x, o_imag_x, o_real_y, o_imag_y, o_mode_x, o_mode_y, o_row_done, o_err} !== '0) begin
            errors++; $display("FAIL rstmid_outputs: trig=%b %h %h %h %h m%b%b want all 0",
                               o_trig, o_real_x, o_imag_x, o_real_y, o_imag_y, o_mode_x, o_mode_y);
        end
        checks++; if (o_busy !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL rstmid_flags: busy=%b ready=%b want 0 1", o_busy, o_ready); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (o_trig !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_flushed: trig=%b busy=%b want 00", o_trig, o_busy); end
        send_beat(12'h0E1, 12'h0E2);
        send_beat(12'h0E3, 12'h0E4);
        wait_trig(t);
        checks++; if (o_mode_x !== 1'b1 || o_real_x !== 12'h0E1 || o_imag_y !== 12'h0E4) begin
            errors++; $display("FAIL rstmid_newpair: mode=%b %h %h want 1 0e1 0e4", o_mode_x, o_real_x, o_imag_y);
        end
        @(negedge clk);
        pulse_finish();
    endtask

    task automatic test_timeout();
        int t;
        do_reset();
        send_beat(12'h0F1, 12'h0F2);
        send_beat(12'h0F3, 12'h0F4);
        wait_trig(t);
        send_beat(12'h0C1, 12'h0C2);
        send_beat(12'h0C3, 12'h0C4);
`ifdef PE_FEEDER_TIMEOUT_EN
        while (cyc < t + 63) @(negedge clk);
        checks++; if (o_err !== 1'b0 || o_trig !== 1'b0) begin errors++; $display("FAIL to_early: err=%b trig=%b want 00", o_err, o_trig); end
        @(negedge clk);
        checks++; if (o_err !== 1'b1 || o_trig !== 1'b0) begin errors++; $display("FAIL to_pulse: err=%b trig=%b want 1 0", o_err, o_trig); end
        @(negedge clk);
        checks++; if (o_err !== 1'b0 || o_trig !== 1'b1 || o_real_x !== 12'h0C1) begin
            errors++; $display("FAIL to_relaunch: err=%b trig=%b real_x=%h want 0 1 0c1", o_err, o_trig, o_real_x);
        end
`else
        while (cyc < t + 100) @(negedge clk);
        checks++; if (o_err !== 1'b0 || o_busy !== 1'b1 || o_trig !== 1'b0) begin
            errors++; $display("FAIL nto_wait: err=%b busy=%b trig=%b want 0 1 0", o_err, o_busy, o_trig);
        end
        pulse_finish();
        checks++; if (o_trig !== 1'b1 || o_real_x !== 12'h0C1) begin
            errors++; $display("FAIL nto_relaunch: trig=%b real_x=%h want 1 0c1", o_trig, o_real_x);
        end
`endif
        @(negedge clk);
        pulse_finish();
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL to_end_busy: got %b want 0", o_busy); end
    endtask

    task automatic test_trig_spacing();
        checks++; if (consec_trig !== 0) begin errors++; $display("FAIL trig_spacing: %0d back-to-back trigger cycles want 0", consec_trig); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_row();
        test_backpressure();
        test_ignored_finish();
        test_reset_mid();
        test_timeout();
        test_trig_spacing();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
